decode_ctrl: RTL and testbench

DECODE_CTRL -- requirements
Module: decode_ctrl

---
 rtl/riscv_lite_pkg.sv | 26 ++
 rtl/instr_use_dec.sv | 62 ++++++
 rtl/decode_ctrl.sv | 135 +++++++++++++
 tb/tb_decode_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lite_pkg.sv
// riscv_lite_pkg -- shared constants and types for the decode controller.
//   REG_AW    : register-address width (5 -> 32 architectural registers)
//   NUM_REGS  : number of architectural registers
//   OP_*      : 7-bit major opcodes this controller recognises
//   state_e   : decode-controller FSM states (RUN, FLUSH)
package riscv_lite_pkg;

  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 1 << REG_AW;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/instr_use_dec.sv
// instr_use_dec -- purely combinational register-usage decoder.
// Ports:
//   instr     in  32  instruction word (standard RV32 field layout)
//   rs1/rs2   out 5   source register fields
//   rd        out 5   destination register field
//   use_rs1   out 1   instruction reads rs1
//   use_rs2   out 1   instruction reads rs2
//   writes_rd out 1   instruction writes rd (never true for rd = x0)
module instr_use_dec
  import riscv_lite_pkg::*;
(
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [REG_AW-1:0] rd,
  output logic              use_rs1,
  output logic              use_rs2,
  output logic              writes_rd
);

  logic [6:0] opcode;
  logic       rd_dest;
  logic       unused_bits;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  // funct3/funct7 do not affect register usage.
  assign unused_bits = ^{instr[31:25], instr[14:12]};

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    rd_dest = 1'b0;
    case (opcode)
      OP_REG: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        rd_dest = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        use_rs1 = 1'b1;
        rd_dest = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_JAL, OP_LUI, OP_AUIPC: begin
        rd_dest = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Writes to x0 are architecturally discarded, so they never create a producer.
  assign writes_rd = rd_dest && (rd != '0);

endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl -- decode-stage hazard / flush controller for a 5-stage pipeline.
// Parameter: NBITS instruction width (decoder uses IR_IN[31:0]; NBITS >= 32).
// Ports:
//   clk, rst (sync, active-high)
//   id_valid, IR_IN                  decode stage instruction
//   ex_rd, ex_mem_read               instruction currently in EX
//   ex_branch_taken                  EX redirect
//   wb_we, wb_rd                     writeback request
//   RegA/RegB/RegIMM_LATCH_EN        decode latch enables (instruction issues)
//   RF_WE                            register-file write enable
//   pc_stall, ex_bubble              stall fetch/decode, inject NOP into EX
//   stall_cnt                        saturating stall-cycle counter
//   dbg_state                        current FSM state
// Build option: define DECODE_CTRL_FWD_EN for a forwarding pipeline, where only
// load-use against EX stalls and no scoreboard is kept. Otherwise a 32-entry
// scoreboard makes consumers wait until their producer's writeback cycle.
//
// Handshake: id_valid marks a valid instruction in decode. It is consumed in a
// cycle where the latch enables are high; while pc_stall is high it is held
// and must be presented again unchanged. A flush discards it (no stall).
module decode_ctrl
  import riscv_lite_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [NBITS-1:0]  IR_IN,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              RegA_LATCH_EN,
  output logic              RegB_LATCH_EN,
  output logic              RegIMM_LATCH_EN,
  output logic              RF_WE,
  output logic              pc_stall,
  output logic              ex_bubble,
  output logic [15:0]       stall_cnt,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic              use_rs1, use_rs2, writes_rd;
  logic              rs1_pend, rs2_pend, hazard, latch_en;
  logic              unused_in;

  assign unused_in = ^{IR_IN, ex_rd, ex_mem_read};

  instr_use_dec u_dec (
    .instr     (IR_IN[31:0]),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .use_rs1   (use_rs1),
    .use_rs2   (use_rs2),
    .writes_rd (writes_rd)
  );

  assign RF_WE = !rst && wb_we && (wb_rd != '0);

`ifdef DECODE_CTRL_FWD_EN
  // Only a load in EX cannot be forwarded in time.
  assign rs1_pend = ex_mem_read && (ex_rd == rs1);
  assign rs2_pend = ex_mem_read && (ex_rd == rs2);
`else
  logic [NUM_REGS-1:0] sb_q, sb_d;

  // Write-before-read in the register file: a register being written back
  // this cycle is already readable, so it no longer blocks.
  assign rs1_pend = sb_q[rs1] && !(RF_WE && (wb_rd == rs1));
  assign rs2_pend = sb_q[rs2] && !(RF_WE && (wb_rd == rs2));

  always_comb begin
    sb_d = sb_q;
    if (RF_WE) sb_d[wb_rd] = 1'b0;
    // Set after clear so a same-cycle set/clear of one register leaves it set.
    if (latch_en && writes_rd) sb_d[rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_d;
  end
`endif

  assign hazard = id_valid &&
                  ((use_rs1 && (rs1 != '0) && rs1_pend) ||
                   (use_rs2 && (rs2 != '0) && rs2_pend));

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Priority: reset > branch redirect > flush cycle > hazard > issue.
  always_comb begin
    state_d   = state_q;
    latch_en  = 1'b0;
    pc_stall  = 1'b0;
    ex_bubble = 1'b0;
    if (rst) begin
      state_d = RUN;
    end else if (ex_branch_taken) begin
      ex_bubble = 1'b1;
      state_d   = FLUSH;
    end else if (state_q == FLUSH) begin
      ex_bubble = 1'b1;
      state_d   = RUN;
    end else if (hazard) begin
      pc_stall  = 1'b1;
      ex_bubble = 1'b1;
    end else begin
      latch_en = id_valid;
    end
  end

  assign RegA_LATCH_EN   = latch_en;
  assign RegB_LATCH_EN   = latch_en;
  assign RegIMM_LATCH_EN = latch_en;
  assign dbg_state       = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (pc_stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl -- randomized and directed bench for decode_ctrl with a
// behavioural model (pending-register set + flush flag + stall counter).
// Honors DECODE_CTRL_FWD_EN the same way as the design.
module tb_decode_ctrl;
  import riscv_lite_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] IR_IN;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_branch_taken;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic        RegA_LATCH_EN, RegB_LATCH_EN, RegIMM_LATCH_EN;
  logic        RF_WE, pc_stall, ex_bubble;
  logic [15:0] stall_cnt;
  state_e      dbg_state;

  always #5 clk = ~clk;

  decode_ctrl #(.NBITS(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .IR_IN           (IR_IN),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .wb_we           (wb_we),
    .wb_rd           (wb_rd),
    .RegA_LATCH_EN   (RegA_LATCH_EN),
    .RegB_LATCH_EN   (RegB_LATCH_EN),
    .RegIMM_LATCH_EN (RegIMM_LATCH_EN),
    .RF_WE           (RF_WE),
    .pc_stall        (pc_stall),
    .ex_bubble       (ex_bubble),
    .stall_cnt       (stall_cnt),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard / checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_pend[32];
  bit m_flush;
  int m_cnt;
  int m_issue_rd;
  logic e_latch, e_stall, e_bubble, e_rfwe;

  function automatic void decode(input logic [31:0] ir, output int rs1, output int rs2,
                                 output int rd, output bit u1, output bit u2, output bit w);
    logic [6:0] op;
    op  = ir[6:0];
    rd  = int'(ir[11:7]);
    rs1 = int'(ir[19:15]);
    rs2 = int'(ir[24:20]);
    u1  = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011};
    u2  = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    w   = (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                      7'b1101111, 7'b0110111, 7'b0010111}) && (rd != 0);
  endfunction

  function automatic bit busy(input int r);
`ifdef DECODE_CTRL_FWD_EN
    return (r != 0) && ex_mem_read && (int'(ex_rd) == r);
`else
    return (r != 0) && m_pend[r] && !(e_rfwe && int'(wb_rd) == r);
`endif
  endfunction

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_flush = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_eval();
    int rs1, rs2, rd;
    bit u1, u2, w, haz;
    decode(IR_IN, rs1, rs2, rd, u1, u2, w);
    e_latch  = 1'b0;
    e_stall  = 1'b0;
    e_bubble = 1'b0;
    e_rfwe   = !rst && wb_we && (wb_rd != 5'd0);
    haz = id_valid && ((u1 && busy(rs1)) || (u2 && busy(rs2)));
    if (rst) begin
    end else if (ex_branch_taken || m_flush) begin
      e_bubble = 1'b1;
    end else if (haz) begin
      e_stall  = 1'b1;
      e_bubble = 1'b1;
    end else begin
      e_latch = id_valid;
    end
    m_issue_rd = (e_latch && w) ? rd : 0;
  endtask

  task automatic model_commit();
    if (rst) begin
      model_reset();
    end else begin
      if (e_rfwe) m_pend[int'(wb_rd)] = 1'b0;
      if (m_issue_rd != 0) m_pend[m_issue_rd] = 1'b1;
      if (e_stall && m_cnt < 65535) m_cnt++;
      m_flush = ex_branch_taken;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic sample();
    #1;
    model_eval();
    check("latch_a", RegA_LATCH_EN, e_latch);
    check("latch_b", RegB_LATCH_EN, e_latch);
    check("latch_imm", RegIMM_LATCH_EN, e_latch);
    check("pc_stall", pc_stall, e_stall);
    check("ex_bubble", ex_bubble, e_bubble);
    check("rf_we", RF_WE, e_rfwe);
    check("stall_cnt", stall_cnt, m_cnt);
    check("state", dbg_state, m_flush ? FLUSH : RUN);
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic set_in(input logic v, input logic [31:0] ir, input logic br,
                        input logic we, input logic [4:0] wrd);
    rst             = 1'b0;
    id_valid        = v;
    IR_IN           = ir;
    ex_branch_taken = br;
    wb_we           = we;
    wb_rd           = wrd;
  endtask

  task automatic do_reset();
    set_in(1'b1, 32'h0000_0033, 1'b1, 1'b1, 5'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] ir;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b1111111};
    ir        = $urandom;
    ir[6:0]   = ops[$urandom_range(0, 9)];
    ir[11:7]  = 5'($urandom_range(0, 7));
    ir[19:15] = 5'($urandom_range(0, 7));
    ir[24:20] = 5'($urandom_range(0, 7));
    return ir;
  endfunction

  // ---------------- stimulus ----------------
  logic [31:0] addi_x3, add_x4;

  initial begin
    addi_x3 = enc(7'b0010011, 5'd3, 5'd0, 5'd1);
    add_x4  = enc(7'b0110011, 5'd4, 5'd3, 5'd3);
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
    ex_rd       = 5'd0;
    ex_mem_read = 1'b0;
    rst         = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();

    // Reset cycle with every request active: outputs must stay quiet.
    do_reset();

`ifdef DECODE_CTRL_FWD_EN
    // Load-use: lw x5 in EX, add x6,x5,x7 in decode.
    set_in(1'b1, enc(7'b0110011, 5'd6, 5'd5, 5'd7), 1'b0, 1'b0, 5'd0);
    ex_mem_read = 1'b1;
    ex_rd       = 5'd5;
    sample();
    check("lu_stall", pc_stall, 1);
    check("lu_bubble", ex_bubble, 1);
    advance();
    ex_mem_read = 1'b0;
    ex_rd       = 5'd0;
    sample();
    check("lu_issue", RegA_LATCH_EN, 1);
    check("lu_cnt", stall_cnt, 1);
    advance();
`else
    // Producer/consumer through the scoreboard.
    set_in(1'b1, addi_x3, 1'b0, 1'b0, 5'd0);
    sample();
    check("prod_issue", RegA_LATCH_EN, 1);
    advance();
    set_in(1'b1, add_x4, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      sample();
      check("cons_stall", pc_stall, 1);
      advance();
    end
    set_in(1'b1, add_x4, 1'b0, 1'b1, 5'd3);
    sample();
    check("cons_issue_wb", RegA_LATCH_EN, 1);
    check("cons_issue_stall", pc_stall, 0);
    advance();

    // Branch taken while decode has a hazard: two bubbles, no stall.
    do_reset();
    set_in(1'b1, addi_x3, 1'b0, 1'b0, 5'd0);
    step();
    set_in(1'b1, add_x4, 1'b1, 1'b0, 5'd0);
    sample();
    check("br_bubble", ex_bubble, 1);
    check("br_stall", pc_stall, 0);
    check("br_latch", RegA_LATCH_EN, 0);
    advance();
    set_in(1'b1, add_x4, 1'b0, 1'b0, 5'd0);
    sample();
    check("fl_bubble", ex_bubble, 1);
    check("fl_stall", pc_stall, 0);
    advance();
    sample();
    check("post_fl_stall", pc_stall, 1);
    advance();

    // Writes to x0 never register a producer; wb to x0 never writes.
    do_reset();
    set_in(1'b1, enc(7'b0110011, 5'd0, 5'd1, 5'd2), 1'b0, 1'b0, 5'd0);
    step();
    set_in(1'b1, {20'h12345, 5'd0, 7'b0110111}, 1'b0, 1'b1, 5'd0);
    sample();
    check("rfwe_x0", RF_WE, 0);
    advance();

    // Reset in the middle of a stall.
    do_reset();
    set_in(1'b1, addi_x3, 1'b0, 1'b0, 5'd0);
    step();
    set_in(1'b1, add_x4, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 7; i++) step();
    sample();
    check("cnt7", stall_cnt, 7);
    advance();
    rst = 1'b1;
    sample();
    check("rst_stall", pc_stall, 0);
    advance();
    rst = 1'b0;
    sample();
    check("rst_cnt", stall_cnt, 0);
    check("rst_state", dbg_state, RUN);
    check("rst_sb_empty", RegA_LATCH_EN, 1);
    advance();
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 99) == 0);
      id_valid        = ($urandom_range(0, 3) != 0);
      IR_IN           = rand_instr();
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      ex_mem_read     = ($urandom_range(0, 3) == 0);
      ex_rd           = 5'($urandom_range(0, 7));
      wb_we           = ($urandom_range(0, 2) == 0);
      wb_rd           = 5'($urandom_range(0, 7));
      step();
    end

    // Saturation of the stall counter under a hazard held far past 65535.
    do_reset();
    ex_mem_read = 1'b0;
    ex_rd       = 5'd0;
`ifdef DECODE_CTRL_FWD_EN
    ex_mem_read = 1'b1;
    ex_rd       = 5'd3;
`else
    set_in(1'b1, addi_x3, 1'b0, 1'b0, 5'd0);
    step();
`endif
    set_in(1'b1, add_x4, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 70000; i++) step();
    sample();
    check("cnt_sat", stall_cnt, 16'hFFFF);
    check("sat_stall", pc_stall, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
